// File: rtl/merge_pkg.sv
// Shared definitions for the merge-sort cascade: entry tag layout, FSM encoding, helpers.
package merge_pkg;

  localparam int DATA_W_DEF = 32;

  // Tag bits sit directly above the data word in each FIFO entry.
  localparam int TAG_RE_OFS = 0;
  localparam int TAG_FL_OFS = 1;

  typedef enum logic [1:0] {
    ST_WAIT_A  = 2'd0,
    ST_MERGE   = 2'd1,
    ST_DRAIN_A = 2'd2,
    ST_DRAIN_B = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/merge_fifo.sv
// Show-ahead synchronous FIFO holding one run of tagged words; push and pop may coincide,
// including on a full FIFO.
module merge_fifo
  import merge_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF + 2,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/merge_stage.sv
// Streaming merge stage: merges pairs of RUN_LEN sorted runs into 2*RUN_LEN runs.
// Optional MERGE_ORDER_CHECK_EN adds the sticky o_order_err input-run order monitor.
//
// state    | meaning
// WAIT_A   | waiting for a complete A run to start the next pair
// MERGE    | comparing A and B heads, popping the winner
// DRAIN_A  | B run finished (or frame ended in A); pass rest of A run
// DRAIN_B  | A run finished; pass rest of B run
module merge_stage
  import merge_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RUN_LEN = 1,
  parameter int DESCEND = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_in,
  input  logic              i_valid_in,
  input  logic              i_last_in,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_out,
  output logic              o_valid_out,
  output logic              o_last_out,
  input  logic              i_out_ready
`ifdef MERGE_ORDER_CHECK_EN
  ,
  output logic              o_order_err
`endif
);

  localparam int ENTRY_W = DATA_W + 2;
  localparam int WCNT_W  = (RUN_LEN > 1) ? clog2(RUN_LEN) : 1;
  localparam int RE_BIT  = DATA_W + TAG_RE_OFS;
  localparam int FL_BIT  = DATA_W + TAG_FL_OFS;

  logic [WCNT_W-1:0]  r_wcnt;
  logic               r_wside;
  logic [1:0]         r_a_done;
  logic               r_a_fl;
  logic               r_pair_last;
  state_t             r_state;
  logic [DATA_W-1:0]  r_out;
  logic               r_valid_out;
  logic               r_last_out;

  state_t             w_state_nxt;
  logic               w_pair_last_nxt;
  logic               w_take_a;
  logic               w_pop_a;
  logic               w_pop_b;
  logic               w_last_pop;
  logic               w_accept;
  logic               w_run_end;
  logic               w_push_a;
  logic               w_push_b;
  logic               w_a_re_wr;
  logic               w_can_pop;
  logic               w_a_wins;
  logic [ENTRY_W-1:0] w_entry;
  logic [ENTRY_W-1:0] w_a_head;
  logic [ENTRY_W-1:0] w_b_head;
  logic [DATA_W-1:0]  w_a_data;
  logic [DATA_W-1:0]  w_b_data;
  logic               w_a_full;
  logic               w_a_empty;
  logic               w_b_full;
  logic               w_b_empty;

  assign o_ready   = r_wside ? !w_b_full : !w_a_full;
  assign w_accept  = i_valid_in && o_ready;
  assign w_run_end = (r_wcnt == WCNT_W'(RUN_LEN - 1)) || i_last_in;
  assign w_entry   = {i_last_in, w_run_end, i_in};
  assign w_push_a  = w_accept && !r_wside;
  assign w_push_b  = w_accept && r_wside;
  assign w_a_re_wr = w_push_a && w_run_end;

  merge_fifo #(.WIDTH(ENTRY_W), .DEPTH(RUN_LEN)) u_fifo_a (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push_a),
    .i_data  (w_entry),
    .i_pop   (w_pop_a),
    .o_data  (w_a_head),
    .o_full  (w_a_full),
    .o_empty (w_a_empty)
  );

  merge_fifo #(.WIDTH(ENTRY_W), .DEPTH(RUN_LEN)) u_fifo_b (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push_b),
    .i_data  (w_entry),
    .i_pop   (w_pop_b),
    .o_data  (w_b_head),
    .o_full  (w_b_full),
    .o_empty (w_b_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wcnt  <= '0;
      r_wside <= 1'b0;
    end else if (w_accept) begin
      if (i_last_in) begin
        r_wcnt  <= '0;
        r_wside <= 1'b0;
      end else if (w_run_end) begin
        r_wcnt  <= '0;
        r_wside <= ~r_wside;
      end else begin
        r_wcnt  <= r_wcnt + 1'b1;
      end
    end
  end

  // Completed A runs waiting to be paired; a_fl marks the one that closes a frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_done <= 2'd0;
      r_a_fl   <= 1'b0;
    end else begin
      if (w_a_re_wr && !w_take_a)      r_a_done <= r_a_done + 2'd1;
      else if (!w_a_re_wr && w_take_a) r_a_done <= r_a_done - 2'd1;
      if (w_a_re_wr) r_a_fl <= i_last_in;
    end
  end

  assign w_a_data  = w_a_head[DATA_W-1:0];
  assign w_b_data  = w_b_head[DATA_W-1:0];
  assign w_a_wins  = (DESCEND != 0) ? (w_a_data >= w_b_data) : (w_a_data <= w_b_data);
  assign w_can_pop = !r_valid_out || i_out_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_pair_last_nxt = r_pair_last;
    w_take_a        = 1'b0;
    w_pop_a         = 1'b0;
    w_pop_b         = 1'b0;
    w_last_pop      = 1'b0;
    case (r_state)
      ST_WAIT_A: begin
        if (r_a_done != 2'd0) begin
          w_take_a        = 1'b1;
          w_pair_last_nxt = r_a_fl;
          w_state_nxt     = r_a_fl ? ST_DRAIN_A : ST_MERGE;
        end
      end
      ST_MERGE: begin
        if (!w_a_empty && !w_b_empty && w_can_pop) begin
          if (w_a_wins) begin
            w_pop_a = 1'b1;
            if (w_a_head[RE_BIT]) w_state_nxt = ST_DRAIN_B;
          end else begin
            w_pop_b = 1'b1;
            if (w_b_head[RE_BIT]) begin
              w_pair_last_nxt = r_pair_last | w_b_head[FL_BIT];
              w_state_nxt     = ST_DRAIN_A;
            end
          end
        end
      end
      ST_DRAIN_A: begin
        if (!w_a_empty && w_can_pop) begin
          w_pop_a = 1'b1;
          if (w_a_head[RE_BIT]) begin
            w_last_pop  = r_pair_last | w_a_head[FL_BIT];
            w_state_nxt = ST_WAIT_A;
          end
        end
      end
      ST_DRAIN_B: begin
        if (!w_b_empty && w_can_pop) begin
          w_pop_b = 1'b1;
          if (w_b_head[RE_BIT]) begin
            w_pair_last_nxt = r_pair_last | w_b_head[FL_BIT];
            w_last_pop      = r_pair_last | w_b_head[FL_BIT];
            w_state_nxt     = ST_WAIT_A;
          end
        end
      end
      default: w_state_nxt = ST_WAIT_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_WAIT_A;
      r_pair_last <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pair_last <= w_pair_last_nxt;
    end
  end

  // Output register: loads on every pop, holds while downstream stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out       <= '0;
      r_valid_out <= 1'b0;
      r_last_out  <= 1'b0;
    end else if (w_pop_a || w_pop_b) begin
      r_out       <= w_pop_a ? w_a_data : w_b_data;
      r_valid_out <= 1'b1;
      r_last_out  <= w_last_pop;
    end else if (i_out_ready) begin
      r_valid_out <= 1'b0;
      r_last_out  <= 1'b0;
    end
  end

  assign o_out       = r_out;
  assign o_valid_out = r_valid_out;
  assign o_last_out  = r_last_out;

`ifdef MERGE_ORDER_CHECK_EN
  logic [DATA_W-1:0] r_prev;
  logic              r_in_run;
  logic              r_order_err;
  logic              w_violate;

  assign w_violate = (DESCEND != 0) ? (i_in > r_prev) : (i_in < r_prev);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev      <= '0;
      r_in_run    <= 1'b0;
      r_order_err <= 1'b0;
    end else if (w_accept) begin
      if (r_in_run && w_violate) r_order_err <= 1'b1;
      r_prev   <= i_in;
      r_in_run <= !w_run_end;
    end
  end

  assign o_order_err = r_order_err;
`endif

endmodule

// File: tb/tb_merge_stage.sv
// Bench for merge_stage: three instances (RUN_LEN 1 asc, 4 asc, 2 desc) against a chunk-sort model.
module tb_merge_stage;

  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] din;
  logic          last_in;
  logic          out_ready;
  logic          vin  [3];
  logic          rdy  [3];
  logic [DW-1:0] dout [3];
  logic          vout [3];
  logic          lout [3];
`ifdef MERGE_ORDER_CHECK_EN
  logic          oerr [3];
`endif

  int vectors = 0;
  int miscompares = 0;

  int unsigned in_q[$];
  bit          inl_q[$];
  int unsigned exp_q[$];
  bit          expl_q[$];
  int unsigned frm[$];
  int unsigned chunk[$];

  merge_stage #(.DATA_W(DW), .RUN_LEN(1), .DESCEND(0)) u_dut_r1 (
    .i_clk(clk), .i_rst(rst), .i_in(din), .i_valid_in(vin[0]), .i_last_in(last_in),
    .o_ready(rdy[0]), .o_out(dout[0]), .o_valid_out(vout[0]), .o_last_out(lout[0]),
    .i_out_ready(out_ready)
`ifdef MERGE_ORDER_CHECK_EN
    , .o_order_err(oerr[0])
`endif
  );

  merge_stage #(.DATA_W(DW), .RUN_LEN(4), .DESCEND(0)) u_dut_r4 (
    .i_clk(clk), .i_rst(rst), .i_in(din), .i_valid_in(vin[1]), .i_last_in(last_in),
    .o_ready(rdy[1]), .o_out(dout[1]), .o_valid_out(vout[1]), .o_last_out(lout[1]),
    .i_out_ready(out_ready)
`ifdef MERGE_ORDER_CHECK_EN
    , .o_order_err(oerr[1])
`endif
  );

  merge_stage #(.DATA_W(DW), .RUN_LEN(2), .DESCEND(1)) u_dut_r2d (
    .i_clk(clk), .i_rst(rst), .i_in(din), .i_valid_in(vin[2]), .i_last_in(last_in),
    .o_ready(rdy[2]), .o_out(dout[2]), .o_valid_out(vout[2]), .o_last_out(lout[2]),
    .i_out_ready(out_ready)
`ifdef MERGE_ORDER_CHECK_EN
    , .o_order_err(oerr[2])
`endif
  );

  function automatic int rl_of(input int s);
    return (s == 0) ? 1 : (s == 1) ? 4 : 2;
  endfunction

  function automatic bit desc_of(input int s);
    return (s == 2);
  endfunction

  function automatic void sort_chunk(input bit desc);
    for (int i = 1; i < chunk.size(); i++) begin
      int unsigned key;
      int j;
      key = chunk[i];
      j = i - 1;
      while (j >= 0 && (desc ? (chunk[j] < key) : (chunk[j] > key))) begin
        chunk[j+1] = chunk[j];
        j--;
      end
      chunk[j+1] = key;
    end
  endfunction

  // Expected output of a frame: every 2*RUN_LEN slice comes out fully sorted.
  task automatic add_frame(input int s);
    int n;
    int w;
    n = frm.size();
    w = 2 * rl_of(s);
    for (int i = 0; i < n; i++) begin
      in_q.push_back(frm[i]);
      inl_q.push_back(i == n - 1);
    end
    for (int base = 0; base < n; base += w) begin
      chunk.delete();
      for (int k = base; k < base + w && k < n; k++) chunk.push_back(frm[k]);
      sort_chunk(desc_of(s));
      for (int k = 0; k < chunk.size(); k++) begin
        exp_q.push_back(chunk[k]);
        expl_q.push_back(base + k == n - 1);
      end
    end
  endtask

  task automatic make_rand_frame(input int s, input int len, input int maxv);
    int rl;
    rl = rl_of(s);
    frm.delete();
    for (int base = 0; base < len; base += rl) begin
      chunk.delete();
      for (int k = base; k < base + rl && k < len; k++)
        chunk.push_back($urandom_range(0, maxv));
      sort_chunk(desc_of(s));
      for (int k = 0; k < chunk.size(); k++) frm.push_back(chunk[k]);
    end
  endtask

  task automatic run_stream(input int s, input int rdy_pct, input int vin_pct,
                            input int budget, input string name);
    int            cyc;
    bit            held;
    logic [DW-1:0] held_v;
    int unsigned   e;
    bit            el;
    cyc  = 0;
    held = 1'b0;
    held_v = '0;
    while ((exp_q.size() != 0 || in_q.size() != 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (held) begin
        vectors++;
        if (vout[s] !== 1'b1 || dout[s] !== held_v) begin
          miscompares++;
          $display("FAIL %s hold: valid=%0b out=%0d, required valid=1 out=%0d",
                   name, vout[s], dout[s], held_v);
        end
      end
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      held = 1'b0;
      if (vout[s] === 1'b1) begin
        if (out_ready) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s extra word: out=%0d last=%0b, required none", name, dout[s], lout[s]);
          end else begin
            e  = exp_q.pop_front();
            el = expl_q.pop_front();
            if (dout[s] !== e || lout[s] !== el) begin
              miscompares++;
              $display("FAIL %s word: out=%0d last=%0b, required out=%0d last=%0b",
                       name, dout[s], lout[s], e, el);
            end
          end
        end else begin
          held   = 1'b1;
          held_v = dout[s];
        end
      end
      if (in_q.size() != 0 && $urandom_range(0, 99) < vin_pct) begin
        vin[s]  = 1'b1;
        din     = in_q[0];
        last_in = inl_q[0];
        if (rdy[s] === 1'b1) begin
          void'(in_q.pop_front());
          void'(inl_q.pop_front());
        end
      end else begin
        vin[s] = 1'b0;
      end
    end
    vin[s] = 1'b0;
    if (exp_q.size() != 0 || in_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: %0d outputs and %0d inputs left, required 0",
               name, exp_q.size(), in_q.size());
      exp_q.delete(); expl_q.delete(); in_q.delete(); inl_q.delete();
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (vout[s] !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle: valid=%0b out=%0d, required valid=0", name, vout[s], dout[s]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      vectors++;
      if (vout[s] !== 1'b0 || dout[s] !== '0 || lout[s] !== 1'b0 || rdy[s] !== 1'b1) begin
        miscompares++;
        $display("FAIL reset dut%0d: valid=%0b out=%0d last=%0b ready=%0b, required 0/0/0/1",
                 s, vout[s], dout[s], lout[s], rdy[s]);
      end
    end
  endtask

  task automatic test_r1_latency();
    @(negedge clk);
    out_ready = 1'b1;
    vin[0] = 1'b1; din = 7; last_in = 1'b0;
    vectors++;
    if (rdy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL r1 ready: ready=%0b, required 1", rdy[0]);
    end
    @(negedge clk);
    din = 3; last_in = 1'b1;
    @(negedge clk);
    vin[0] = 1'b0; last_in = 1'b0;
    vectors++;
    if (vout[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL r1 early valid: valid=%0b, required 0", vout[0]);
    end
    @(negedge clk);
    vectors++;
    if (vout[0] !== 1'b1 || dout[0] !== 32'd3 || lout[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL r1 first: valid=%0b out=%0d last=%0b, required 1/3/0", vout[0], dout[0], lout[0]);
    end
    @(negedge clk);
    vectors++;
    if (vout[0] !== 1'b1 || dout[0] !== 32'd7 || lout[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL r1 second: valid=%0b out=%0d last=%0b, required 1/7/1", vout[0], dout[0], lout[0]);
    end
    @(negedge clk);
    vectors++;
    if (vout[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL r1 end: valid=%0b, required 0", vout[0]);
    end
  endtask

  task automatic test_r4_merge();
    frm = '{1, 5, 9, 13, 2, 3, 10, 20};
    add_frame(1);
    run_stream(1, 100, 100, 200, "r4_merge");
  endtask

  task automatic test_partial_frames();
    frm = '{4, 6, 8, 9, 5, 7};
    add_frame(1);
    frm = '{2, 8, 9};
    add_frame(1);
    frm = '{6, 7, 8, 9, 1, 2, 3, 4};
    add_frame(1);
    run_stream(1, 100, 100, 300, "partial");
  endtask

  task automatic test_descend();
    frm = '{9, 4, 9, 1};
    add_frame(2);
    run_stream(2, 100, 100, 200, "descend");
  endtask

  // With the output stalled only one word can leave A, so exactly 9 words fit.
  task automatic test_backpressure();
    int acc;
    acc = 0;
    frm = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
    add_frame(1);
    out_ready = 1'b0;
    repeat (30) begin
      @(negedge clk);
      vin[1]  = 1'b1;
      din     = in_q[0];
      last_in = inl_q[0];
      if (rdy[1] === 1'b1) begin
        void'(in_q.pop_front());
        void'(inl_q.pop_front());
        acc++;
      end
    end
    @(negedge clk);
    vin[1] = 1'b0;
    vectors++;
    if (acc != 9 || rdy[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL bp fill: accepted=%0d ready=%0b, required 9/0", acc, rdy[1]);
    end
    vectors++;
    if (vout[1] !== 1'b1 || dout[1] !== 32'd1 || lout[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL bp held: valid=%0b out=%0d last=%0b, required 1/1/0", vout[1], dout[1], lout[1]);
    end
    run_stream(1, 100, 100, 300, "bp_drain");
  endtask

  task automatic test_random();
    for (int f = 0; f < 100; f++) begin
      make_rand_frame(1, $urandom_range(1, 20), 50);
      add_frame(1);
    end
    run_stream(1, 50, 80, 20000, "rand_r4");
    for (int f = 0; f < 30; f++) begin
      make_rand_frame(2, $urandom_range(1, 9), 20);
      add_frame(2);
    end
    run_stream(2, 50, 80, 5000, "rand_r2d");
    for (int f = 0; f < 30; f++) begin
      make_rand_frame(0, $urandom_range(1, 5), 1000);
      add_frame(0);
    end
    run_stream(0, 50, 80, 5000, "rand_r1");
  endtask

  task automatic test_reset_mid();
    int unsigned pre [5];
    pre = '{10, 20, 30, 40, 5};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vin[1] = 1'b1; din = pre[i]; last_in = 1'b0;
    end
    @(negedge clk);
    vin[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (vout[1] !== 1'b0 || dout[1] !== '0 || lout[1] !== 1'b0 || rdy[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL mid reset: valid=%0b out=%0d last=%0b ready=%0b, required 0/0/0/1",
               vout[1], dout[1], lout[1], rdy[1]);
    end
    frm = '{3, 5, 7, 9, 1, 2, 4, 6};
    add_frame(1);
    run_stream(1, 100, 100, 200, "after_reset");
  endtask

`ifdef MERGE_ORDER_CHECK_EN
  task automatic test_order_check();
    vectors++;
    if (oerr[1] !== 1'b0 || oerr[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL order idle: err_r4=%0b err_r2d=%0b, required 0/0", oerr[1], oerr[2]);
    end
    in_q.push_back(5); inl_q.push_back(1'b0);
    in_q.push_back(3); inl_q.push_back(1'b1);
    exp_q.push_back(5); expl_q.push_back(1'b0);
    exp_q.push_back(3); expl_q.push_back(1'b1);
    run_stream(1, 100, 100, 200, "order_run");
    vectors++;
    if (oerr[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL order flag: err=%0b, required 1", oerr[1]);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (oerr[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL order clear: err=%0b, required 0", oerr[1]);
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    din       = '0;
    last_in   = 1'b0;
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) vin[s] = 1'b0;
    test_reset();
    test_r1_latency();
    test_r4_merge();
    test_partial_frames();
    test_descend();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef MERGE_ORDER_CHECK_EN
    test_order_check();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
